// File: rtl/hive_power_pkg.sv
// Shared power-management constants (mV/10 units) and the voltage sequencer state encoding.
package hive_power_pkg;

   localparam logic [7:0] VOLTAGE_DEEPSLEEP = 8'd40;
   localparam logic [7:0] VOLTAGE_STANDBY   = 8'd60;
   localparam logic [7:0] VOLTAGE_ACTIVE    = 8'd100;

   typedef enum logic [2:0] {
      SEQ_IDLE   = 3'd0,
      SEQ_RAMP   = 3'd1,
      SEQ_SETTLE = 3'd2,
      SEQ_STABLE = 3'd3,
      SEQ_FAULT  = 3'd4
   } seq_state_e;

   // Clamp a requested voltage into the legal window [lo, hi].
   function automatic logic [7:0] clamp_mv10(input logic [7:0] v,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/pmu_voltage_sequencer.sv
// Slew-limited regulator voltage sequencer: ramps the DAC code toward a clamped
// target, waits for settle and power-good, and latches a fault on timeout or pgood loss.
module pmu_voltage_sequencer
   import hive_power_pkg::*;
#(
   parameter int unsigned STEP_MV10      = 2,
   parameter int unsigned STEP_CYCLES    = 100,
   parameter int unsigned SETTLE_CYCLES  = 500,
   parameter int unsigned TIMEOUT_CYCLES = 2000,
   parameter int unsigned VMIN           = 40,
   parameter int unsigned VMAX           = 110
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        voltage_request,
   input  logic [7:0]  voltage_target,
   input  logic        pgood,
   input  logic        fault_clear,
   output logic        voltage_stable,
   output logic [7:0]  dac_code,
   output logic        dac_update,
   output logic        ramping,
   output logic        fault,
   output logic        irq_fault,
   output logic [15:0] ramp_count
);

   localparam int unsigned MAX_A   = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int unsigned TW      = $clog2(MAX_CYC + 1);

   seq_state_e       r_state;
   logic [7:0]       r_tgt;
   logic [7:0]       r_dac;
   logic [TW-1:0]    r_timer;
   logic             r_to_phase;
   logic             r_stable;
   logic             r_dac_update;
   logic             r_ramping;
   logic             r_fault;
   logic             r_irq;
   logic [15:0]      r_ramp_count;

   logic [7:0]        w_tgt_clamped;
   logic signed [8:0] w_diff;
   logic [8:0]        w_mag;
   logic [7:0]        w_step;
   logic [7:0]        w_dac_next;

   // Next DAC code: move toward the target by at most STEP_MV10, never past it.
   assign w_tgt_clamped = clamp_mv10(voltage_target, 8'(VMIN), 8'(VMAX));
   assign w_diff        = $signed({1'b0, r_tgt}) - $signed({1'b0, r_dac});
   assign w_mag         = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);
   assign w_step        = (w_mag > 9'(STEP_MV10)) ? 8'(STEP_MV10) : w_mag[7:0];
   assign w_dac_next    = w_diff[8] ? (r_dac - w_step) : (r_dac + w_step);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= SEQ_IDLE;
         r_tgt        <= VOLTAGE_ACTIVE;
         r_dac        <= VOLTAGE_ACTIVE;
         r_timer      <= '0;
         r_to_phase   <= 1'b0;
         r_stable     <= 1'b0;
         r_dac_update <= 1'b0;
         r_ramping    <= 1'b0;
         r_fault      <= 1'b0;
         r_irq        <= 1'b0;
         r_ramp_count <= '0;
      end else begin
         r_dac_update <= 1'b0;
         r_irq        <= 1'b0;
         case (r_state)
            SEQ_IDLE: begin
               if (voltage_request) begin
                  r_tgt      <= w_tgt_clamped;
                  r_timer    <= '0;
                  r_to_phase <= 1'b0;
                  r_ramping  <= 1'b1;
                  r_state    <= (w_tgt_clamped != r_dac) ? SEQ_RAMP : SEQ_SETTLE;
               end
            end
            SEQ_RAMP, SEQ_SETTLE: begin
               if (!voltage_request) begin
                  r_state   <= SEQ_IDLE;
                  r_ramping <= 1'b0;
               end else if (w_tgt_clamped != r_tgt) begin
                  // Retarget mid-flight: restart from the present code with a fresh step period.
                  r_tgt      <= w_tgt_clamped;
                  r_timer    <= '0;
                  r_to_phase <= 1'b0;
                  r_state    <= (w_tgt_clamped != r_dac) ? SEQ_RAMP : SEQ_SETTLE;
               end else if (r_state == SEQ_RAMP) begin
                  if (r_timer == TW'(STEP_CYCLES - 1)) begin
                     r_timer      <= '0;
                     r_dac        <= w_dac_next;
                     r_dac_update <= 1'b1;
                     if (w_dac_next == r_tgt) r_state <= SEQ_SETTLE;
                  end else begin
                     r_timer <= r_timer + TW'(1);
                  end
               end else if (!r_to_phase) begin
                  if (r_timer == TW'(SETTLE_CYCLES - 1)) begin
                     r_timer <= '0;
                     if (pgood) begin
                        r_state   <= SEQ_STABLE;
                        r_stable  <= 1'b1;
                        r_ramping <= 1'b0;
                        if (r_ramp_count != 16'hFFFF) r_ramp_count <= r_ramp_count + 16'd1;
                     end else begin
                        r_to_phase <= 1'b1;
                     end
                  end else begin
                     r_timer <= r_timer + TW'(1);
                  end
               end else begin
                  // Settled but pgood still low: bounded wait before declaring a fault.
                  if (pgood) begin
                     r_state   <= SEQ_STABLE;
                     r_stable  <= 1'b1;
                     r_ramping <= 1'b0;
                     if (r_ramp_count != 16'hFFFF) r_ramp_count <= r_ramp_count + 16'd1;
                  end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                     r_state   <= SEQ_FAULT;
                     r_fault   <= 1'b1;
                     r_irq     <= 1'b1;
                     r_ramping <= 1'b0;
                  end else begin
                     r_timer <= r_timer + TW'(1);
                  end
               end
            end
            SEQ_STABLE: begin
               if (!voltage_request) begin
                  r_state  <= SEQ_IDLE;
                  r_stable <= 1'b0;
               end else if (!pgood) begin
                  r_state  <= SEQ_FAULT;
                  r_stable <= 1'b0;
                  r_fault  <= 1'b1;
                  r_irq    <= 1'b1;
               end
            end
            SEQ_FAULT: begin
               if (fault_clear) begin
                  r_state <= SEQ_IDLE;
                  r_fault <= 1'b0;
               end
            end
            default: begin
               r_state   <= SEQ_IDLE;
               r_stable  <= 1'b0;
               r_ramping <= 1'b0;
               r_fault   <= 1'b0;
            end
         endcase
      end
   end

   assign voltage_stable = r_stable;
   assign dac_code       = r_dac;
   assign dac_update     = r_dac_update;
   assign ramping        = r_ramping;
   assign fault          = r_fault;
   assign irq_fault      = r_irq;
   assign ramp_count     = r_ramp_count;

endmodule

// File: tb/tb_pmu_voltage_sequencer.sv
// Bench for pmu_voltage_sequencer: a scoreboard of expected DAC steps (code and cycle)
// is filled by the scenario tasks and drained by a monitor on every dac_update pulse.
module tb_pmu_voltage_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        voltage_request = 1'b0;
   logic [7:0]  voltage_target = 8'd0;
   logic        pgood = 1'b1;
   logic        fault_clear = 1'b0;
   logic        voltage_stable;
   logic [7:0]  dac_code;
   logic        dac_update;
   logic        ramping;
   logic        fault;
   logic        irq_fault;
   logic [15:0] ramp_count;

   typedef struct {
      logic [7:0] code;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   pmu_voltage_sequencer dut (
      .clk(clk), .rst_n(rst_n), .voltage_request(voltage_request),
      .voltage_target(voltage_target), .pgood(pgood), .fault_clear(fault_clear),
      .voltage_stable(voltage_stable), .dac_code(dac_code), .dac_update(dac_update),
      .ramping(ramping), .fault(fault), .irq_fault(irq_fault), .ramp_count(ramp_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every DAC update must match the next expected step in value and cycle.
   always @(negedge clk) begin
      if (dac_update) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: dac_code=%0d at cycle %0d, no update expected", dac_code, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (dac_code !== e.code || cyc != e.cyc) begin
               errors++;
               $display("FAIL sb_step: got code %0d at cycle %0d, want code %0d at cycle %0d",
                        dac_code, cyc, e.code, e.cyc);
            end
         end
      end
   end

   // Reference ramp: 2 mV/10 per step every 100 cycles, final step trimmed to land on target.
   task automatic push_ramp(input int from, input int to, input int start, output int last);
      int v;
      int c;
      int d;
      int s;
      v = from;
      c = start;
      while (v != to) begin
         d = to - v;
         s = (d > 2) ? 2 : ((d < -2) ? -2 : d);
         v = v + s;
         c = c + 100;
         sb.push_back('{8'(v), c});
      end
      last = c;
   endtask

   // Bounded wait at negedges; sel 0: voltage_stable, 1: fault, 2: dac_code==val.
   task automatic wait_until(input int sel, input int val, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if ((sel == 0 && voltage_stable === 1'b1) || (sel == 1 && fault === 1'b1) ||
             (sel == 2 && dac_code === 8'(val))) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pgood = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (dac_code !== 8'd100) begin errors++; $display("FAIL reset_dac_in_reset: got %0d want 100", dac_code); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (dac_code !== 8'd100) begin errors++; $display("FAIL reset_dac: got %0d want 100", dac_code); end
      checks++;
      if ({voltage_stable, dac_update, ramping, fault, irq_fault} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 00000", {voltage_stable, dac_update, ramping, fault, irq_fault});
      end
      checks++;
      if (ramp_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ramp_count); end
   endtask

   task automatic test_ramp_down();
      int acc;
      int last;
      bit ok;
      voltage_target = 8'd60;
      voltage_request = 1'b1;
      acc = cyc + 1;
      push_ramp(100, 60, acc, last);
      @(negedge clk);
      checks++;
      if (voltage_stable !== 1'b0 || ramping !== 1'b1) begin
         errors++; $display("FAIL accept_flags: stable=%b ramping=%b want 0 1", voltage_stable, ramping);
      end
      wait_until(0, 0, 2700, ok);
      checks++;
      if (!ok || cyc != last + 500) begin
         errors++; $display("FAIL down_stable_time: ok=%0d cycle %0d want %0d", ok, cyc, last + 500);
      end
      checks++;
      if (dac_code !== 8'd60 || ramp_count !== 16'd1 || ramping !== 1'b0 || sb.size() != 0) begin
         errors++; $display("FAIL down_end: dac=%0d count=%0d ramping=%b pending=%0d want 60 1 0 0",
                            dac_code, ramp_count, ramping, sb.size());
      end
      voltage_request = 1'b0;
      @(negedge clk);
      checks++;
      if (voltage_stable !== 1'b0) begin errors++; $display("FAIL drop_stable: got %b want 0", voltage_stable); end
   endtask

   task automatic test_odd_step_and_clamp();
      int last;
      bit ok;
      voltage_target = 8'd41;
      voltage_request = 1'b1;
      push_ramp(60, 41, cyc + 1, last);
      @(negedge clk);
      wait_until(0, 0, 1700, ok);
      checks++;
      if (!ok || cyc != last + 500 || dac_code !== 8'd41 || ramp_count !== 16'd2) begin
         errors++; $display("FAIL odd_step_end: ok=%0d cycle %0d dac=%0d count=%0d want cycle %0d dac 41 count 2",
                            ok, cyc, dac_code, ramp_count, last + 500);
      end
      voltage_request = 1'b0;
      @(negedge clk);
      voltage_target = 8'd200;
      voltage_request = 1'b1;
      push_ramp(41, 110, cyc + 1, last);
      @(negedge clk);
      wait_until(0, 0, 4200, ok);
      checks++;
      if (!ok || cyc != last + 500 || dac_code !== 8'd110 || ramp_count !== 16'd3) begin
         errors++; $display("FAIL clamp_end: ok=%0d cycle %0d dac=%0d count=%0d want cycle %0d dac 110 count 3",
                            ok, cyc, dac_code, ramp_count, last + 500);
      end
      voltage_request = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fault_timeout();
      int last;
      int clr;
      bit ok;
      pgood = 1'b0;
      voltage_target = 8'd40;
      voltage_request = 1'b1;
      push_ramp(110, 40, cyc + 1, last);
      @(negedge clk);
      wait_until(1, 0, 6200, ok);
      checks++;
      if (!ok || cyc != last + 2500 || irq_fault !== 1'b1 || voltage_stable !== 1'b0) begin
         errors++; $display("FAIL fault_entry: ok=%0d cycle %0d irq=%b stable=%b want cycle %0d irq 1 stable 0",
                            ok, cyc, irq_fault, voltage_stable, last + 2500);
      end
      @(negedge clk);
      checks++;
      if (irq_fault !== 1'b0 || fault !== 1'b1 || ramping !== 1'b0) begin
         errors++; $display("FAIL fault_hold: irq=%b fault=%b ramping=%b want 0 1 0", irq_fault, fault, ramping);
      end
      pgood = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (fault !== 1'b1 || dac_code !== 8'd40) begin
         errors++; $display("FAIL fault_sticky: fault=%b dac=%0d want 1 40", fault, dac_code);
      end
      fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
      clr = cyc;
      checks++;
      if (fault !== 1'b0 || ramping !== 1'b0) begin
         errors++; $display("FAIL fault_clear_idle: fault=%b ramping=%b want 0 0", fault, ramping);
      end
      @(negedge clk);
      checks++;
      if (ramping !== 1'b1) begin errors++; $display("FAIL reaccept: ramping=%b want 1", ramping); end
      wait_until(0, 0, 700, ok);
      checks++;
      if (!ok || cyc != clr + 501 || ramp_count !== 16'd4) begin
         errors++; $display("FAIL reaccept_stable: ok=%0d cycle %0d count=%0d want cycle %0d count 4",
                            ok, cyc, ramp_count, clr + 501);
      end
      fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
      checks++;
      if (voltage_stable !== 1'b1 || fault !== 1'b0) begin
         errors++; $display("FAIL stray_clear: stable=%b fault=%b want 1 0", voltage_stable, fault);
      end
      pgood = 1'b0;
      @(negedge clk);
      pgood = 1'b1;
      checks++;
      if (fault !== 1'b1 || irq_fault !== 1'b1 || voltage_stable !== 1'b0) begin
         errors++; $display("FAIL pgood_loss: fault=%b irq=%b stable=%b want 1 1 0", fault, irq_fault, voltage_stable);
      end
      voltage_request = 1'b0;
      fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL pgood_loss_clear: fault=%b want 0", fault); end
   endtask

   task automatic test_reverse_and_abort();
      int last;
      int last2;
      bit ok;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      voltage_target = 8'd40;
      voltage_request = 1'b1;
      push_ramp(100, 70, cyc + 1, last);
      @(negedge clk);
      wait_until(2, 70, 1700, ok);
      checks++;
      if (!ok || cyc != last) begin errors++; $display("FAIL reach_70: ok=%0d cycle %0d want %0d", ok, cyc, last); end
      voltage_target = 8'd80;
      push_ramp(70, 80, last + 1, last2);
      wait_until(0, 0, 1200, ok);
      checks++;
      if (!ok || cyc != last2 + 500 || dac_code !== 8'd80 || ramp_count !== 16'd1) begin
         errors++; $display("FAIL reverse_end: ok=%0d cycle %0d dac=%0d count=%0d want cycle %0d dac 80 count 1",
                            ok, cyc, dac_code, ramp_count, last2 + 500);
      end
      voltage_request = 1'b0;
      @(negedge clk);
      voltage_target = 8'd40;
      voltage_request = 1'b1;
      push_ramp(80, 76, cyc + 1, last);
      @(negedge clk);
      wait_until(2, 76, 300, ok);
      voltage_request = 1'b0;
      repeat (300) @(negedge clk);
      checks++;
      if (!ok || dac_code !== 8'd76 || ramp_count !== 16'd1 || ramping !== 1'b0 || voltage_stable !== 1'b0 || sb.size() != 0) begin
         errors++; $display("FAIL abort_hold: ok=%0d dac=%0d count=%0d ramping=%b stable=%b pending=%0d want 1 76 1 0 0 0",
                            ok, dac_code, ramp_count, ramping, voltage_stable, sb.size());
      end
   endtask

   task automatic test_async_reset();
      int last;
      bit ok;
      voltage_target = 8'd40;
      voltage_request = 1'b1;
      push_ramp(76, 64, cyc + 1, last);
      @(negedge clk);
      wait_until(2, 64, 800, ok);
      checks++;
      if (!ok || cyc != last) begin errors++; $display("FAIL reach_64: ok=%0d cycle %0d want %0d", ok, cyc, last); end
      repeat (30) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dac_code !== 8'd100 || ramp_count !== 16'd0) begin
         errors++; $display("FAIL async_reset_dac: dac=%0d count=%0d want 100 0", dac_code, ramp_count);
      end
      checks++;
      if ({voltage_stable, dac_update, ramping, fault, irq_fault} !== 5'b0) begin
         errors++; $display("FAIL async_reset_flags: got %b want 00000", {voltage_stable, dac_update, ramping, fault, irq_fault});
      end
      voltage_request = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0 || dac_code !== 8'd100) begin
         errors++; $display("FAIL post_reset: pending=%0d dac=%0d want 0 100", sb.size(), dac_code);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_down();
      test_odd_step_and_clamp();
      test_fault_timeout();
      test_reverse_and_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
